pipe_hazard_ctrl: RTL and testbench

//  Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.

---
 rtl/pipe_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush sequencer: memory stalls, load-use bubbles, branch redirects, WFI sleep/wake.
// Optional stall performance counter enabled by defining STALL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             im_stall,
  input  logic             dm_stall,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             wfi_dec,
  input  logic             irq_pending,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             sleeping,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_SLEEP = 2'd2;
  localparam logic [1:0] ST_WAKE  = 2'd3;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

  logic [1:0]    state_reg, state_next;
  logic [DW-1:0] drain_cnt_reg, drain_cnt_next;
  logic          mstall;

  assign mstall = im_stall | dm_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_RUN;
      drain_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
    end
  end

  always_comb begin
    pc_en          = 1'b0;
    if_id_en       = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_en       = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_en      = 1'b0;
    mem_wb_en      = 1'b0;
    sleeping       = 1'b0;
    state_next     = state_reg;
    drain_cnt_next = drain_cnt_reg;

    if (!rst) begin
      if (mstall) begin
        // Memory stall freezes everything; pending decisions are retaken once it clears.
        sleeping = (state_reg == ST_SLEEP);
      end else begin
        case (state_reg)
          ST_RUN: begin
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if (branch_taken) begin
              pc_en       = 1'b1;
              if_id_en    = 1'b1;
              if_id_flush = 1'b1;
              id_ex_flush = 1'b1;
            end else if (load_use) begin
              id_ex_flush = 1'b1;
            end else if (wfi_dec && !irq_pending) begin
              id_ex_flush    = 1'b1;
              state_next     = ST_DRAIN;
              drain_cnt_next = DRAIN_INIT;
            end else begin
              pc_en    = 1'b1;
              if_id_en = 1'b1;
            end
          end
          ST_DRAIN: begin
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
            if (irq_pending) begin
              state_next = ST_WAKE;
            end else if (drain_cnt_reg == '0) begin
              state_next = ST_SLEEP;
            end else begin
              drain_cnt_next = drain_cnt_reg - DW'(1);
            end
          end
          ST_SLEEP: begin
            sleeping = 1'b1;
            if (irq_pending) begin
              state_next = ST_WAKE;
            end
          end
          default: begin
            // Discard the WFI held in IF/ID and resume fetch at the next PC.
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
            state_next  = ST_RUN;
          end
        endcase
      end
    end
  end

`ifdef STALL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (!pc_en && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, corner-case sequences, randomized run.
module tb_pipe_hazard_ctrl;

  localparam int DRAIN_CYCLES = 3;
  localparam int CNT_W        = 4;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, sleeping}
  localparam logic [7:0] V_ZERO   = 8'b0000_0000;
  localparam logic [7:0] V_RUN    = 8'b1101_0110;
  localparam logic [7:0] V_BRANCH = 8'b1111_1110;
  localparam logic [7:0] V_BUBBLE = 8'b0001_1110;
  localparam logic [7:0] V_SLEEP  = 8'b0000_0001;
  localparam logic [7:0] V_WAKE   = 8'b1111_1110;

  logic clk = 1'b0;
  logic rst, im_stall, dm_stall, load_use, branch_taken, wfi_dec, irq_pending;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, sleeping;
  logic [CNT_W-1:0] stall_cnt;
  logic [7:0] outs;

  int checks = 0;
  int failures = 0;

  typedef enum int {M_RUN, M_DRAIN, M_SLEEP, M_WAKE} mode_t;
  mode_t mode;
  int    drained;
  int    exp_cnt;

  typedef struct {
    logic im, dm, lu, br, wfi, irq;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[9];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .im_stall(im_stall), .dm_stall(dm_stall),
    .load_use(load_use), .branch_taken(branch_taken), .wfi_dec(wfi_dec),
    .irq_pending(irq_pending), .pc_en(pc_en), .if_id_en(if_id_en),
    .if_id_flush(if_id_flush), .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .sleeping(sleeping),
    .stall_cnt(stall_cnt)
  );

  assign outs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, sleeping};

  // Reference behaviour derived directly from the stage rules.
  function automatic logic [7:0] model_out();
    if (rst) return V_ZERO;
    if (im_stall || dm_stall) return (mode == M_SLEEP) ? V_SLEEP : V_ZERO;
    case (mode)
      M_RUN: begin
        if (branch_taken) return V_BRANCH;
        if (load_use) return V_BUBBLE;
        if (wfi_dec && !irq_pending) return V_BUBBLE;
        return V_RUN;
      end
      M_DRAIN: return V_BUBBLE;
      M_SLEEP: return V_SLEEP;
      default: return V_WAKE;
    endcase
  endfunction

  task automatic model_reset();
    mode    = M_RUN;
    drained = 0;
    exp_cnt = 0;
  endtask

  task automatic tick();
    logic [7:0] o;
    @(posedge clk);
    o = model_out();
    if (rst) begin
      model_reset();
    end else begin
`ifdef STALL_PERF_EN
      if (!o[7] && exp_cnt < CNT_MAX) exp_cnt++;
`endif
      if (!(im_stall || dm_stall)) begin
        case (mode)
          M_RUN: if (!branch_taken && !load_use && wfi_dec && !irq_pending) begin
            mode = M_DRAIN;
            drained = 0;
          end
          M_DRAIN: begin
            if (irq_pending) mode = M_WAKE;
            else begin
              drained++;
              if (drained >= DRAIN_CYCLES) mode = M_SLEEP;
            end
          end
          M_SLEEP: if (irq_pending) mode = M_WAKE;
          default: mode = M_RUN;
        endcase
      end
    end
    #1;
  endtask

  task automatic set_in(input logic im, input logic dm, input logic lu,
                        input logic br, input logic wfi, input logic irq);
    im_stall = im; dm_stall = dm; load_use = lu;
    branch_taken = br; wfi_dec = wfi; irq_pending = irq;
  endtask

  // Compare outputs (explicit or model expectation) and the stall counter, then advance one cycle.
  task automatic step(input string name, input logic use_model, input logic [7:0] exp_in);
    logic [7:0] exp;
    @(negedge clk);
    exp = use_model ? model_out() : exp_in;
    checks++;
    if (outs !== exp) begin
      failures++;
      $display("FAIL %s outs=%b expected=%b", name, outs, exp);
    end
    checks++;
    if (stall_cnt !== CNT_W'(exp_cnt)) begin
      failures++;
      $display("FAIL %s_cnt stall_cnt=%0d expected=%0d", name, stall_cnt, exp_cnt);
    end
    $display("step %-12s in=%b%b%b%b%b%b outs=%b cnt=%0d", name, im_stall, dm_stall,
             load_use, branch_taken, wfi_dec, irq_pending, outs, stall_cnt);
    tick();
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end else begin
      $display("check %-12s got=%0d", name, act);
    end
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_RUN};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, V_BRANCH};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, V_BUBBLE};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, V_ZERO};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, V_ZERO};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, V_RUN};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, V_BUBBLE};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, V_BRANCH};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_RUN};

    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    model_reset();
    step("reset0", 0, V_ZERO);
    set_in(0, 0, 1, 1, 1, 1);
    step("reset_in", 0, V_ZERO);
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 9; i++) begin
      set_in(tbl[i].im, tbl[i].dm, tbl[i].lu, tbl[i].br, tbl[i].wfi, tbl[i].irq);
      step($sformatf("tbl%0d", i), 0, tbl[i].exp);
    end

    // Memory stall over a taken branch, then the redirect once it clears.
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, 0, 1, 0, 0);
      step($sformatf("mstall%0d", i), 0, V_ZERO);
    end
    set_in(0, 0, 0, 1, 0, 0);
    step("br_release", 0, V_BRANCH);

    set_in(0, 0, 1, 0, 0, 0);
    step("lu_once", 0, V_BUBBLE);
    set_in(0, 0, 0, 0, 0, 0);
    step("lu_after", 0, V_RUN);

    // WFI, full drain, sleep, wake.
    set_in(0, 0, 0, 0, 1, 0);
    step("wfi", 0, V_BUBBLE);
    set_in(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < DRAIN_CYCLES; i++) step($sformatf("drain%0d", i), 0, V_BUBBLE);
    set_in(0, 0, 0, 0, 0, 0);
    step("sleep0", 0, V_SLEEP);
    set_in(1, 0, 0, 0, 0, 1);
    step("sleep_mst", 0, V_SLEEP);
    set_in(0, 0, 0, 0, 0, 1);
    step("sleep_irq", 0, V_SLEEP);
    set_in(0, 0, 0, 0, 0, 0);
    step("wake", 0, V_WAKE);
    step("run_again", 0, V_RUN);

    // Interrupt arriving mid-drain, plus a memory stall holding WAKE.
    set_in(0, 0, 0, 0, 1, 0);
    step("wfi2", 0, V_BUBBLE);
    set_in(0, 0, 0, 0, 0, 0);
    step("drain_a", 0, V_BUBBLE);
    set_in(0, 0, 0, 0, 0, 1);
    step("drain_irq", 0, V_BUBBLE);
    set_in(0, 1, 0, 0, 0, 0);
    step("wake_hold", 0, V_ZERO);
    set_in(0, 0, 0, 0, 0, 0);
    step("wake2", 0, V_WAKE);
    step("run2", 0, V_RUN);

    // Asynchronous reset while asleep.
    set_in(0, 0, 0, 0, 1, 0);
    step("wfi3", 0, V_BUBBLE);
    set_in(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DRAIN_CYCLES; i++) step($sformatf("drain3_%0d", i), 0, V_BUBBLE);
    step("sleep3", 0, V_SLEEP);
    #2 rst = 1'b1;
    #1;
    check_val("async_sleep", int'(sleeping), 0);
    check_val("async_outs", int'(outs), 0);
    model_reset();
    step("rst_hold", 0, V_ZERO);
    rst = 1'b0;
    check_val("rst_cnt", int'(stall_cnt), 0);
    step("post_rst", 0, V_RUN);

    // Counter saturation under a long instruction-memory stall.
    set_in(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step($sformatf("imst%0d", i), 0, V_ZERO);
    @(negedge clk);
`ifdef STALL_PERF_EN
    check_val("cnt_sat", int'(stall_cnt), CNT_MAX);
`else
    check_val("cnt_off", int'(stall_cnt), 0);
`endif
    tick();
    set_in(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(99) < 10, $urandom_range(99) < 10, $urandom_range(99) < 15,
             $urandom_range(99) < 15, $urandom_range(99) < 15, $urandom_range(99) < 20);
      step($sformatf("rnd%0d", i), 1, V_ZERO);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
